// File: rtl/vgg_ctrl_pkg.sv
// Shared constants and state encoding for the VGG16 stage sequencer.
package vgg_ctrl_pkg;

    localparam int unsigned NUM_STAGES_DEF = 5;

    localparam int unsigned STG_BLOCK1 = 0;
    localparam int unsigned STG_BLOCK2 = 1;
    localparam int unsigned STG_BLOCK3 = 2;
    localparam int unsigned STG_BLOCK4 = 3;
    localparam int unsigned STG_DENSE  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FINISH = 3'd3,
        ST_ERROR  = 3'd4
    } sched_state_e;

endpackage

// File: rtl/vgg_stage_scheduler_if.sv
// Control/status bundle between the chain controller and the stage scheduler.
interface vgg_stage_scheduler_if
    import vgg_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = NUM_STAGES_DEF,
    parameter int STAGE_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    parameter int CNT_WIDTH  = 32
);
    logic                  i_start;
    logic                  i_abort;
    logic [NUM_STAGES-1:0] i_stage_done;
    logic [NUM_STAGES-1:0] o_stage_start;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_error;
    logic [STAGE_W-1:0]    o_cur_stage;
    logic [CNT_WIDTH-1:0]  o_stage_cycles;
    logic                  o_stage_cycles_valid;

    modport master (
        output i_start, i_abort, i_stage_done,
        input  o_stage_start, o_busy, o_done, o_error, o_cur_stage,
               o_stage_cycles, o_stage_cycles_valid
    );

    modport slave (
        input  i_start, i_abort, i_stage_done,
        output o_stage_start, o_busy, o_done, o_error, o_cur_stage,
               o_stage_cycles, o_stage_cycles_valid
    );
endinterface

// File: rtl/stage_cycle_counter.sv
// Saturating per-stage cycle counter; load starts a new count at 1.
module stage_cycle_counter #(
    parameter int                   CNT_WIDTH      = 32,
    parameter logic [CNT_WIDTH-1:0] TIMEOUT_CYCLES = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 en,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 at_limit
);
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_WIDTH'(1);
        end else if (en && (count != '1)) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    assign at_limit = (count == TIMEOUT_CYCLES);
endmodule

// File: rtl/vgg_stage_scheduler.sv
// Launches the VGG16 stages in order, one at a time, with per-stage timeout and profiling.
//  state  | meaning
//  IDLE   | waiting for i_start
//  LAUNCH | one-cycle start pulse to the current stage
//  WAIT   | counting until the current stage reports done or times out
//  FINISH | o_done pulse after the last stage
//  ERROR  | a stage hung; sticky error until the next i_start
module vgg_stage_scheduler
    import vgg_ctrl_pkg::*;
#(
    parameter int                   NUM_STAGES     = NUM_STAGES_DEF,
    parameter int                   STAGE_W        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    parameter int                   CNT_WIDTH      = 32,
    parameter logic [CNT_WIDTH-1:0] TIMEOUT_CYCLES = CNT_WIDTH'(32'hFFFF_FFF0)
) (
    input logic                  clk,
    input logic                  rst,
    vgg_stage_scheduler_if.slave bus
);
    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_LAUNCH = ST_LAUNCH;
    localparam logic [2:0] S_WAIT   = ST_WAIT;
    localparam logic [2:0] S_FINISH = ST_FINISH;
    localparam logic [2:0] S_ERROR  = ST_ERROR;

    logic [2:0]           state, state_nxt;
    logic [STAGE_W-1:0]   idx, idx_nxt;
    logic                 launch;
    logic                 report;
    logic                 cur_done;
    logic                 cur_last;
    logic                 cnt_en;
    logic [CNT_WIDTH-1:0] count;
    logic                 at_limit;

    assign cur_done = bus.i_stage_done[idx];
    assign cur_last = (idx == STAGE_W'(NUM_STAGES - 1));
    assign cnt_en   = (state == S_LAUNCH) || (state == S_WAIT);

    stage_cycle_counter #(
        .CNT_WIDTH      (CNT_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (launch),
        .en       (cnt_en),
        .count    (count),
        .at_limit (at_limit)
    );

    // Abort outranks done, done outranks timeout, everything outranks start.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        launch    = 1'b0;
        report    = 1'b0;
        case (state)
            S_IDLE, S_ERROR: begin
                if (bus.i_start && !bus.i_abort) begin
                    state_nxt = S_LAUNCH;
                    idx_nxt   = '0;
                    launch    = 1'b1;
                end
            end
            S_LAUNCH: state_nxt = bus.i_abort ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (bus.i_abort) begin
                    state_nxt = S_IDLE;
                end else if (cur_done) begin
                    report = 1'b1;
                    if (cur_last) begin
                        state_nxt = S_FINISH;
                    end else begin
                        state_nxt = S_LAUNCH;
                        idx_nxt   = idx + STAGE_W'(1);
                        launch    = 1'b1;
                    end
                end else if (at_limit) begin
                    state_nxt = S_ERROR;
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                    <= S_IDLE;
            idx                      <= '0;
            bus.o_stage_start        <= '0;
            bus.o_busy               <= 1'b0;
            bus.o_done               <= 1'b0;
            bus.o_error              <= 1'b0;
            bus.o_stage_cycles       <= '0;
            bus.o_stage_cycles_valid <= 1'b0;
        end else begin
            state                    <= state_nxt;
            idx                      <= idx_nxt;
            bus.o_stage_start        <= launch ? (NUM_STAGES'(1) << idx_nxt) : '0;
            bus.o_busy               <= (state_nxt == S_LAUNCH) || (state_nxt == S_WAIT) ||
                                        (state_nxt == S_FINISH);
            bus.o_done               <= (state_nxt == S_FINISH);
            bus.o_error              <= (state_nxt == S_ERROR);
            bus.o_stage_cycles_valid <= report;
            if (report) begin
                bus.o_stage_cycles <= count;
            end
        end
    end

    assign bus.o_cur_stage = idx;
endmodule

// File: tb/tb_vgg_stage_scheduler.sv
// Bench for vgg_stage_scheduler: table-driven nominal run plus timeout/abort/reset sequences.
module tb_vgg_stage_scheduler;
    import vgg_ctrl_pkg::*;

    localparam int NS = 3;
    localparam int SW = 2;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vgg_stage_scheduler_if #(.NUM_STAGES(NS), .STAGE_W(SW), .CNT_WIDTH(CW)) bus ();

    vgg_stage_scheduler #(
        .NUM_STAGES     (NS),
        .CNT_WIDTH      (CW),
        .TIMEOUT_CYCLES (32'd20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        int          lc;
        logic        start;
        logic        abort;
        logic [NS-1:0] done;
        int          push_rpt;
        logic [NS-1:0] x_start;
        logic        x_busy;
        logic        x_done;
        logic        x_valid;
        logic        x_err;
        logic [SW-1:0] x_cur;
    } vec_t;

    typedef struct packed {
        int            lc;
        logic [NS-1:0] vec;
    } start_ev_t;

    int        total = 0;
    int        bad   = 0;
    int        lc    = 0;
    int        sb_q[$];
    start_ev_t start_log[$];
    start_ev_t start_exp[$];
    vec_t      tbl[16];
    int        stage_order[5];

    function automatic vec_t mk(int c, logic st, logic ab, logic [NS-1:0] dn, int rpt,
                                logic [NS-1:0] xs, logic xb, logic xd, logic xv, logic xe,
                                logic [SW-1:0] xc);
        vec_t v;
        v.lc = c; v.start = st; v.abort = ab; v.done = dn; v.push_rpt = rpt;
        v.x_start = xs; v.x_busy = xb; v.x_done = xd; v.x_valid = xv; v.x_err = xe;
        v.x_cur = xc;
        return v;
    endfunction

    function automatic logic [NS-1:0] onehot(int k);
        logic [NS-1:0] one;
        one = NS'(1);
        return one << k;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s lc=%0d got=%0h want=%0h", nm, lc, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [NS-1:0] xs, input logic xb,
                              input logic xd, input logic xv, input logic xe,
                              input logic [SW-1:0] xc);
        chk({tag, ".start"}, 64'(bus.o_stage_start), 64'(xs));
        chk({tag, ".busy"},  64'(bus.o_busy), 64'(xb));
        chk({tag, ".done"},  64'(bus.o_done), 64'(xd));
        chk({tag, ".valid"}, 64'(bus.o_stage_cycles_valid), 64'(xv));
        chk({tag, ".error"}, 64'(bus.o_error), 64'(xe));
        chk({tag, ".cur"},   64'(bus.o_cur_stage), 64'(xc));
    endtask

    task automatic tick();
        start_ev_t ev;
        int        want;
        @(posedge clk);
        #1;
        lc++;
        bus.i_start      = 1'b0;
        bus.i_abort      = 1'b0;
        bus.i_stage_done = '0;
        if (bus.o_stage_start != '0) begin
            ev.lc  = lc;
            ev.vec = bus.o_stage_start;
            start_log.push_back(ev);
        end
        if (bus.o_stage_cycles_valid) begin
            chk("rpt_pending", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                want = sb_q.pop_front();
                chk("rpt_cycles", 64'(bus.o_stage_cycles), 64'(want));
            end
        end
    endtask

    task automatic goto_lc(input int c);
        while (lc < c) tick();
    endtask

    task automatic exp_start(input int c, input int k);
        start_ev_t ev;
        ev.lc  = c;
        ev.vec = onehot(k);
        start_exp.push_back(ev);
    endtask

    task automatic new_seq();
        lc = 0;
        start_log.delete();
        start_exp.delete();
        sb_q.delete();
    endtask

    task automatic end_seq(input string tag);
        int n;
        chk({tag, ".rpt_drained"}, 64'(sb_q.size()), 64'd0);
        chk({tag, ".start_count"}, 64'(start_log.size()), 64'(start_exp.size()));
        n = (start_log.size() < start_exp.size()) ? start_log.size() : start_exp.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, ".start_lc"},  64'(start_log[i].lc),  64'(start_exp[i].lc));
            chk({tag, ".start_vec"}, 64'(start_log[i].vec), 64'(start_exp[i].vec));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog lc=%0d got=timeout want=finish", lc);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        stage_order = '{STG_BLOCK1, STG_BLOCK2, STG_BLOCK3, STG_BLOCK4, STG_DENSE};

        // Nominal chain with a stray done and a start request while busy folded in.
        tbl[0]  = mk(0,  1, 0, 3'b000, 0,  3'b000, 0, 0, 0, 0, 2'd0);
        tbl[1]  = mk(1,  0, 0, 3'b000, 0,  onehot(stage_order[0]), 1, 0, 0, 0, 2'd0);
        tbl[2]  = mk(2,  0, 0, 3'b000, 0,  3'b000, 1, 0, 0, 0, 2'd0);
        tbl[3]  = mk(5,  0, 0, 3'b100, 0,  3'b000, 1, 0, 0, 0, 2'd0);
        tbl[4]  = mk(6,  0, 0, 3'b000, 0,  3'b000, 1, 0, 0, 0, 2'd0);
        tbl[5]  = mk(10, 0, 0, 3'b001, 10, 3'b000, 1, 0, 0, 0, 2'd0);
        tbl[6]  = mk(11, 0, 0, 3'b000, 0,  onehot(stage_order[1]), 1, 0, 1, 0, 2'd1);
        tbl[7]  = mk(12, 0, 0, 3'b000, 0,  3'b000, 1, 0, 0, 0, 2'd1);
        tbl[8]  = mk(18, 1, 0, 3'b000, 0,  3'b000, 1, 0, 0, 0, 2'd1);
        tbl[9]  = mk(19, 0, 0, 3'b000, 0,  3'b000, 1, 0, 0, 0, 2'd1);
        tbl[10] = mk(25, 0, 0, 3'b010, 15, 3'b000, 1, 0, 0, 0, 2'd1);
        tbl[11] = mk(26, 0, 0, 3'b000, 0,  onehot(stage_order[2]), 1, 0, 1, 0, 2'd2);
        tbl[12] = mk(33, 0, 0, 3'b001, 0,  3'b000, 1, 0, 0, 0, 2'd2);
        tbl[13] = mk(40, 0, 0, 3'b100, 15, 3'b000, 1, 0, 0, 0, 2'd2);
        tbl[14] = mk(41, 0, 0, 3'b000, 0,  3'b000, 1, 1, 1, 0, 2'd2);
        tbl[15] = mk(42, 0, 0, 3'b000, 0,  3'b000, 0, 0, 0, 0, 2'd2);

        bus.i_start      = 1'b0;
        bus.i_abort      = 1'b0;
        bus.i_stage_done = '0;
        rst              = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 3'b000, 0, 0, 0, 0, 2'd0);
        chk("reset.cycles", 64'(bus.o_stage_cycles), 64'd0);
        rst = 1'b0;

        new_seq();
        exp_start(1, 0);
        exp_start(11, 1);
        exp_start(26, 2);
        for (int i = 0; i < 16; i++) begin
            goto_lc(tbl[i].lc);
            check_outs($sformatf("nom%0d", tbl[i].lc), tbl[i].x_start, tbl[i].x_busy,
                       tbl[i].x_done, tbl[i].x_valid, tbl[i].x_err, tbl[i].x_cur);
            bus.i_start      = tbl[i].start;
            bus.i_abort      = tbl[i].abort;
            bus.i_stage_done = tbl[i].done;
            if (tbl[i].push_rpt > 0) sb_q.push_back(tbl[i].push_rpt);
        end
        goto_lc(44);
        end_seq("nominal");

        // Stage 1 hangs: counter reaches 20 at lc 25, error at lc 26; restart, then abort+done.
        new_seq();
        bus.i_start = 1'b1;
        exp_start(1, 0);
        goto_lc(5);
        bus.i_stage_done = 3'b001;
        sb_q.push_back(5);
        exp_start(6, 1);
        goto_lc(25);
        check_outs("to_pre", 3'b000, 1, 0, 0, 0, 2'd1);
        goto_lc(26);
        check_outs("to_hit", 3'b000, 0, 0, 0, 1, 2'd1);
        goto_lc(28);
        check_outs("to_sticky", 3'b000, 0, 0, 0, 1, 2'd1);
        goto_lc(30);
        bus.i_start = 1'b1;
        exp_start(31, 0);
        goto_lc(31);
        check_outs("to_restart", 3'b001, 1, 0, 0, 0, 2'd0);
        goto_lc(35);
        bus.i_stage_done = 3'b001;
        bus.i_abort      = 1'b1;
        goto_lc(36);
        check_outs("abort", 3'b000, 0, 0, 0, 0, 2'd0);
        goto_lc(40);
        check_outs("abort_quiet", 3'b000, 0, 0, 0, 0, 2'd0);
        end_seq("timeout_abort");

        // Reset during stage 2 WAIT, then a full chain with a done ignored in LAUNCH.
        new_seq();
        bus.i_start = 1'b1;
        exp_start(1, 0);
        goto_lc(3);
        bus.i_stage_done = 3'b001;
        sb_q.push_back(3);
        exp_start(4, 1);
        goto_lc(6);
        bus.i_stage_done = 3'b010;
        sb_q.push_back(3);
        exp_start(7, 2);
        goto_lc(10);
        check_outs("pre_rst", 3'b000, 1, 0, 0, 0, 2'd2);
        rst = 1'b1;
        goto_lc(11);
        check_outs("mid_rst", 3'b000, 0, 0, 0, 0, 2'd0);
        chk("mid_rst.cycles", 64'(bus.o_stage_cycles), 64'd0);
        rst         = 1'b0;
        bus.i_start = 1'b1;
        exp_start(12, 0);
        goto_lc(12);
        check_outs("post_rst", 3'b001, 1, 0, 0, 0, 2'd0);
        goto_lc(14);
        bus.i_stage_done = 3'b001;
        sb_q.push_back(3);
        exp_start(15, 1);
        goto_lc(17);
        bus.i_stage_done = 3'b010;
        sb_q.push_back(3);
        exp_start(18, 2);
        goto_lc(18);
        bus.i_stage_done = 3'b100;
        goto_lc(19);
        check_outs("launch_done", 3'b000, 1, 0, 0, 0, 2'd2);
        goto_lc(20);
        bus.i_stage_done = 3'b100;
        sb_q.push_back(3);
        goto_lc(21);
        check_outs("rst_fin", 3'b000, 1, 1, 1, 0, 2'd2);
        goto_lc(22);
        check_outs("rst_idle", 3'b000, 0, 0, 0, 0, 2'd2);
        end_seq("reset_mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vgg_stage_scheduler.md
# vgg_stage_scheduler

Top-level sequencer for the VGG16 feature-extraction chain. It launches each convolution block stage (block_2conv / block_3conv instances and the downstream dense stage) in order, one at a time. Each stage gets a one-cycle start pulse on its `i_valid`, and the scheduler waits for that stage's `o_valid` completion pulse before launching the next. It also watches every stage with a timeout, supports abort, and reports per-stage cycle counts for profiling.

## Interface
Parameters:
- `NUM_STAGES`, 5: number of sequenced stages (index 0 launched first).
- `STAGE_W`, `$clog2(NUM_STAGES)` (minimum 1): width of the stage index.
- `CNT_WIDTH`, 32: width of the per-stage cycle counter.
- `TIMEOUT_CYCLES`, 32'hFFFF_FFF0: counter value at which a running stage is declared hung; must be at most 2^CNT_WIDTH−1.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  one-cycle request to run the full chain.
- `i_abort`  in  1  one-cycle request to stop the chain.
- `i_stage_done`  in  NUM_STAGES  per-stage completion pulses (stage `o_valid`).
- `o_stage_start`  out  NUM_STAGES  one-hot start pulse (stage `i_valid`).
- `o_busy`  out  1  chain in progress.
- `o_done`  out  1  one-cycle pulse: all stages completed.
- `o_error`  out  1  sticky timeout flag.
- `o_cur_stage`  out  STAGE_W  index of the current or last stage.
- `o_stage_cycles`  out  CNT_WIDTH  cycle count of the last finished stage.
- `o_stage_cycles_valid`  out  1  one-cycle pulse qualifying `o_stage_cycles`.

## Operation
States: `IDLE`, `LAUNCH`, `WAIT`, `FINISH`, `ERROR`.

- **IDLE**
  - `i_start` → `LAUNCH`; stage index ← 0; `o_error` cleared.
  - `i_abort` in IDLE has no effect.
- **LAUNCH** (exactly one cycle)
  - `o_stage_start[idx]` = 1; counter ← 1.
  - Always goes to `WAIT`, unless `i_abort` is high (→ `IDLE`).
- **WAIT**
  - Counter increments by 1 each cycle, saturating at all-ones.
  - `i_stage_done[idx]` high:
    - latch `o_stage_cycles` ← counter and pulse `o_stage_cycles_valid`;
    - if idx = NUM_STAGES−1 → `FINISH`, else idx+1 and → `LAUNCH`.
  - Done bits for any stage other than idx are ignored; no state change and no error.
  - Counter reaches `TIMEOUT_CYCLES` with no done → `ERROR`.
- **FINISH** (one cycle): `o_done` = 1, then → `IDLE`.
- **ERROR**
  - `o_error` = 1 and stays set; `o_busy` = 0; `o_cur_stage` holds the hung stage index.
  - `i_start` → `LAUNCH` at stage 0 and clears `o_error`.
- **Priority:** `rst` > `i_abort` > done/timeout > `i_start`.
  - Abort in LAUNCH, WAIT or FINISH → `IDLE` with no `o_done` and no cycle report.
  - Done and timeout in the same cycle: done wins.
- `i_start` while not in IDLE or ERROR is ignored; requests are not queued.

## Timing
- **Reset:** state `IDLE`, idx 0, counter 0. All outputs 0: `o_stage_start`, `o_busy`, `o_done`, `o_error`, `o_cur_stage`, `o_stage_cycles`, `o_stage_cycles_valid`.
- All outputs are registered.
- `i_start` sampled at cycle t:
  - `o_stage_start[0]` = 1 and `o_busy` = 1 at t+1.
  - `o_busy` stays 1 through the `FINISH` cycle.
- Done of stage k sampled at cycle d (k < NUM_STAGES−1):
  - `o_stage_cycles_valid` = 1 at d+1;
  - `o_stage_start[k+1]` = 1 at d+1 (`LAUNCH`).
- Done of the last stage sampled at cycle d: `o_done` and `o_stage_cycles_valid` both = 1 at d+1; `o_busy` = 0 at d+2.
- Reported cycle count = number of cycles from the `LAUNCH` cycle through the done cycle, inclusive.
- Timeout: `o_error` rises the cycle after the counter equals `TIMEOUT_CYCLES`.

## Structure
- Shared package `vgg_ctrl_pkg` holds:
  - the state enum;
  - the default `NUM_STAGES`;
  - the stage-index constants (`STG_BLOCK1` … `STG_DENSE`).
- One natural sub-module, `stage_cycle_counter`: saturating counter with clear, enable and a compare against `TIMEOUT_CYCLES`.
- The FSM and the one-hot start decode stay in the top module.

## Test plan
- **Nominal run:** NUM_STAGES=3; start at cycle 0; dones at 10, 25, 40.
  - Starts at 1, 11, 26.
  - Cycle reports 10, 15, 15.
  - `o_done` at 41; `o_busy` 0 at 42.
- **Stray done:** `i_stage_done[2]` pulsed while stage 0 runs.
  - Ignored; no launch; stage 0 completes normally.
- **Timeout:** TIMEOUT_CYCLES=20; stage 1 never completes.
  - `o_error` = 1 with `o_cur_stage` = 1.
  - A later `i_start` clears the error and relaunches stage 0.
- **Abort:** abort and done asserted in the same WAIT cycle.
  - → `IDLE`; no next start; no `o_done`; no cycle report.
- **Start while busy:** `i_start` asserted mid-chain.
  - No restart; stage sequence unchanged.
- **Reset mid-run:** `rst` during WAIT of stage 2.
  - All outputs 0 next cycle.
  - A following `i_start` launches stage 0.
